// File: rtl/useq_pkg.sv
// Shared types and constants for the microcode sequencer.
package useq_pkg;

    localparam int unsigned NEXT_W = 2;
    localparam int unsigned RET_W  = 16;

    typedef enum logic [NEXT_W-1:0] {
        SEQ      = 2'b00,
        DISPATCH = 2'b01,
        FETCH    = 2'b10,
        WAIT     = 2'b11
    } useq_next_e;

    typedef enum logic {
        RUN    = 1'b0,
        HALTED = 1'b1
    } useq_state_e;

    localparam int unsigned OPC_RR   = 32'h0;
    localparam int unsigned OPC_IMM  = 32'h1;
    localparam int unsigned OPC_HALT = 32'hF;

    localparam int unsigned UPC_FETCH = 0;
    localparam int unsigned UPC_RR    = 3;
    localparam int unsigned UPC_IMM   = 6;

endpackage

// File: rtl/useq_dispatch_rom.sv
// Opcode to microcode entry map; unmapped opcodes return to fetch and flag illegal.
module useq_dispatch_rom
    import useq_pkg::*;
#(
    parameter int unsigned UPC_W = 4,
    parameter int unsigned OPC_W = 4
) (
    input  logic [OPC_W-1:0] opc,
    output logic [UPC_W-1:0] target,
    output logic             halt,
    output logic             illegal
);

    always_comb begin
        target  = UPC_W'(UPC_FETCH);
        halt    = 1'b0;
        illegal = 1'b0;
        case (opc)
            OPC_W'(OPC_RR):   target = UPC_W'(UPC_RR);
            OPC_W'(OPC_IMM):  target = UPC_W'(UPC_IMM);
            OPC_W'(OPC_HALT): halt   = 1'b1;
            default:          illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/micro_sequencer.sv
// Microcode sequencer: drives the control-store address and holds the IR.
// Optional retire counter port enabled by MICRO_SEQUENCER_RETIRE_CNT_EN.
module micro_sequencer
    import useq_pkg::*;
#(
    parameter int unsigned UPC_W = 4,
    parameter int unsigned OPC_W = 4,
    parameter int unsigned RF_W  = 15
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [1:0]            next,
    input  logic                  ir_ld,
    input  logic [OPC_W+RF_W-1:0] instr,
    input  logic                  mem_ack,
    input  logic                  stall,
    input  logic                  start,
    output logic [UPC_W-1:0]      uPC,
    output logic [RF_W-1:0]       r,
    output logic                  busy,
`ifdef MICRO_SEQUENCER_RETIRE_CNT_EN
    output logic                  illegal,
    output logic [RET_W-1:0]      retired
`else
    output logic                  illegal
`endif
);

    localparam int unsigned IR_W = OPC_W + RF_W;

    useq_next_e       nxt;
    useq_state_e      state_q;
    useq_state_e      state_d;
    logic [IR_W-1:0]  ir_q;
    logic [UPC_W-1:0] upc_d;
    logic             illegal_d;
    logic [UPC_W-1:0] rom_target;
    logic             rom_halt;
    logic             rom_illegal;

    assign nxt = useq_next_e'(next);
    assign r   = ir_q[RF_W-1:0];

    // Dispatch always looks at the registered opcode, never the incoming one.
    useq_dispatch_rom #(
        .UPC_W (UPC_W),
        .OPC_W (OPC_W)
    ) u_rom (
        .opc     (ir_q[IR_W-1:RF_W]),
        .target  (rom_target),
        .halt    (rom_halt),
        .illegal (rom_illegal)
    );

    always_ff @(posedge clk) begin
        if (!reset_n) state_q <= RUN;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (!stall) begin
            case (state_q)
                RUN:     if (nxt == DISPATCH && rom_halt) state_d = HALTED;
                HALTED:  if (start) state_d = RUN;
                default: state_d = RUN;
            endcase
        end
    end

    always_comb begin
        upc_d     = uPC;
        illegal_d = 1'b0;
        if (!stall) begin
            if (state_q == RUN) begin
                case (nxt)
                    SEQ:      upc_d = uPC + UPC_W'(1);
                    DISPATCH: begin
                        upc_d     = rom_target;
                        illegal_d = rom_illegal;
                    end
                    FETCH:    upc_d = UPC_W'(UPC_FETCH);
                    WAIT:     if (mem_ack) upc_d = uPC + UPC_W'(1);
                    default:  upc_d = uPC;
                endcase
            end else begin
                upc_d = UPC_W'(UPC_FETCH);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            uPC     <= '0;
            ir_q    <= '0;
            busy    <= 1'b1;
            illegal <= 1'b0;
        end else begin
            uPC     <= upc_d;
            busy    <= (state_d == RUN);
            illegal <= illegal_d;
            if (!stall && ir_ld) ir_q <= instr;
        end
    end

`ifdef MICRO_SEQUENCER_RETIRE_CNT_EN
    // A FETCH action in RUN marks one retired instruction.
    always_ff @(posedge clk) begin
        if (!reset_n)
            retired <= '0;
        else if (!stall && state_q == RUN && nxt == FETCH)
            retired <= retired + RET_W'(1);
    end
`endif

endmodule

// File: tb/tb_micro_sequencer.sv
// Directed self-checking bench for micro_sequencer.
module tb_micro_sequencer;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [1:0]  next;
    logic        ir_ld;
    logic [18:0] instr;
    logic        mem_ack;
    logic        stall;
    logic        start;
    logic [3:0]  upc;
    logic [14:0] r;
    logic        busy;
    logic        illegal;
`ifdef MICRO_SEQUENCER_RETIRE_CNT_EN
    logic [15:0] retired;
`endif

    int total = 0;
    int bad   = 0;

    micro_sequencer dut (
        .clk     (clk),
        .reset_n (reset_n),
        .next    (next),
        .ir_ld   (ir_ld),
        .instr   (instr),
        .mem_ack (mem_ack),
        .stall   (stall),
        .start   (start),
        .uPC     (upc),
        .r       (r),
        .busy    (busy),
`ifdef MICRO_SEQUENCER_RETIRE_CNT_EN
        .illegal (illegal),
        .retired (retired)
`else
        .illegal (illegal)
`endif
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0; next = 2'b00; ir_ld = 1'b0; instr = '0;
        mem_ack = 1'b0; stall = 1'b0; start = 1'b0;
        step();
        total++;
        if (upc !== 4'd0 || r !== 15'd0 || busy !== 1'b1 || illegal !== 1'b0) begin
            bad++;
            $display("FAIL reset upc=%0d r=%h busy=%b ill=%b exp 0/0/1/0", upc, r, busy, illegal);
        end
`ifdef MICRO_SEQUENCER_RETIRE_CNT_EN
        total++;
        if (retired !== 16'd0) begin bad++; $display("FAIL reset_ret got=%0d exp=0", retired); end
`endif
        reset_n = 1'b1;
    endtask

    task automatic test_seq_rr();
        logic [3:0] exp_upc [3];
        logic [1:0] codes   [3];
        exp_upc = '{4'd1, 4'd2, 4'd3};
        codes   = '{2'b00, 2'b00, 2'b01};
        ir_ld = 1'b1; instr = {4'h0, 15'h1234};
        for (int i = 0; i < 3; i++) begin
            next = codes[i];
            step();
            ir_ld = 1'b0;
            total++;
            if (upc !== exp_upc[i]) begin
                bad++; $display("FAIL seq_rr[%0d] upc got=%0d exp=%0d", i, upc, exp_upc[i]);
            end
        end
        total++;
        if (r !== 15'h1234) begin bad++; $display("FAIL seq_rr_r got=%h exp=1234", r); end
    endtask

    task automatic test_imm();
        logic [3:0] exp_upc [5];
        logic [1:0] codes   [5];
        exp_upc = '{4'd4, 4'd6, 4'd7, 4'd8, 4'd0};
        codes   = '{2'b00, 2'b01, 2'b00, 2'b00, 2'b10};
        ir_ld = 1'b1; instr = 19'h0ABCD;
        for (int i = 0; i < 5; i++) begin
            next = codes[i];
            step();
            ir_ld = 1'b0;
            total++;
            if (upc !== exp_upc[i]) begin
                bad++; $display("FAIL imm[%0d] upc got=%0d exp=%0d", i, upc, exp_upc[i]);
            end
        end
        total++;
        if (r !== 15'h2BCD) begin bad++; $display("FAIL imm_r got=%h exp=2bcd", r); end
`ifdef MICRO_SEQUENCER_RETIRE_CNT_EN
        total++;
        if (retired !== 16'd1) begin bad++; $display("FAIL imm_ret got=%0d exp=1", retired); end
`endif
    endtask

    task automatic test_illegal();
        ir_ld = 1'b1; instr = {4'h5, 15'h0}; next = 2'b00;
        step();
        ir_ld = 1'b0; next = 2'b01;
        step();
        total++;
        if (upc !== 4'd0 || illegal !== 1'b1 || busy !== 1'b1) begin
            bad++; $display("FAIL ill_disp upc=%0d ill=%b busy=%b exp 0/1/1", upc, illegal, busy);
        end
        next = 2'b00;
        step();
        total++;
        if (upc !== 4'd1 || illegal !== 1'b0) begin
            bad++; $display("FAIL ill_pulse upc=%0d ill=%b exp 1/0", upc, illegal);
        end
        // Same-cycle load and dispatch must use the old (illegal) opcode.
        ir_ld = 1'b1; instr = {4'h1, 15'h0042}; next = 2'b01;
        step();
        ir_ld = 1'b0;
        total++;
        if (upc !== 4'd0 || illegal !== 1'b1 || r !== 15'h0042) begin
            bad++; $display("FAIL ill_old upc=%0d ill=%b r=%h exp 0/1/0042", upc, illegal, r);
        end
    endtask

    task automatic test_halt();
        ir_ld = 1'b1; instr = {4'hF, 15'h0}; next = 2'b00;
        step();
        ir_ld = 1'b0; next = 2'b01;
        step();
        total++;
        if (upc !== 4'd0 || busy !== 1'b0 || illegal !== 1'b0) begin
            bad++; $display("FAIL halt upc=%0d busy=%b ill=%b exp 0/0/0", upc, busy, illegal);
        end
        for (int i = 0; i < 10; i++) begin
            next = 2'($urandom_range(0, 3));
            mem_ack = 1'($urandom_range(0, 1));
            step();
            total++;
            if (upc !== 4'd0 || busy !== 1'b0) begin
                bad++; $display("FAIL halted[%0d] upc=%0d busy=%b exp 0/0", i, upc, busy);
            end
        end
        mem_ack = 1'b0; next = 2'b10;
`ifdef MICRO_SEQUENCER_RETIRE_CNT_EN
        total++;
        if (retired !== 16'd1) begin bad++; $display("FAIL halt_ret got=%0d exp=1", retired); end
`endif
        stall = 1'b1; start = 1'b1;
        step();
        total++;
        if (busy !== 1'b0) begin bad++; $display("FAIL halt_stall busy=%b exp 0", busy); end
        stall = 1'b0;
        step();
        start = 1'b0; next = 2'b00;
        total++;
        if (busy !== 1'b1 || upc !== 4'd0) begin
            bad++; $display("FAIL start busy=%b upc=%0d exp 1/0", busy, upc);
        end
    endtask

    task automatic test_wait();
        next = 2'b00;
        for (int i = 0; i < 4; i++) step();
        total++;
        if (upc !== 4'd4) begin bad++; $display("FAIL wait_pre upc=%0d exp=4", upc); end
        next = 2'b11; mem_ack = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            total++;
            if (upc !== 4'd4) begin bad++; $display("FAIL wait_hold[%0d] upc=%0d exp=4", i, upc); end
        end
        mem_ack = 1'b1;
        step();
        total++;
        if (upc !== 4'd5) begin bad++; $display("FAIL wait_ack upc=%0d exp=5", upc); end
        stall = 1'b1; ir_ld = 1'b1; instr = {4'h0, 15'h7777};
        step();
        total++;
        if (upc !== 4'd5 || r !== 15'h0000) begin
            bad++; $display("FAIL wait_stall upc=%0d r=%h exp 5/0000", upc, r);
        end
        stall = 1'b0; ir_ld = 1'b0;
        step();
        total++;
        if (upc !== 4'd6) begin bad++; $display("FAIL wait_unstall upc=%0d exp=6", upc); end
        step();
        total++;
        if (upc !== 4'd7) begin bad++; $display("FAIL wait_immediate upc=%0d exp=7", upc); end
        mem_ack = 1'b0;
    endtask

    task automatic test_stall_illegal();
        ir_ld = 1'b1; instr = {4'h9, 15'h0}; next = 2'b00;
        step();
        ir_ld = 1'b0; stall = 1'b1; next = 2'b01;
        step();
        total++;
        if (upc !== 4'd8 || illegal !== 1'b0) begin
            bad++; $display("FAIL stall_disp upc=%0d ill=%b exp 8/0", upc, illegal);
        end
        stall = 1'b0; next = 2'b00;
    endtask

    task automatic test_wrap();
        for (int i = 0; i < 7; i++) step();
        total++;
        if (upc !== 4'd15) begin bad++; $display("FAIL wrap_pre upc=%0d exp=15", upc); end
        step();
        total++;
        if (upc !== 4'd0) begin bad++; $display("FAIL wrap upc=%0d exp=0", upc); end
    endtask

    task automatic test_reset_wait();
        ir_ld = 1'b1; instr = {4'h5, 15'h7FFF}; next = 2'b00;
        step();
        ir_ld = 1'b0; next = 2'b11; mem_ack = 1'b0;
        step();
        total++;
        if (upc !== 4'd1 || r !== 15'h7FFF) begin
            bad++; $display("FAIL rw_pre upc=%0d r=%h exp 1/7fff", upc, r);
        end
        reset_n = 1'b0;
        step();
        total++;
        if (upc !== 4'd0 || r !== 15'd0 || illegal !== 1'b0 || busy !== 1'b1) begin
            bad++; $display("FAIL rw upc=%0d r=%h ill=%b busy=%b exp 0/0/0/1", upc, r, illegal, busy);
        end
        reset_n = 1'b1; next = 2'b00;
    endtask

    initial begin
        test_reset();
        test_seq_rr();
        test_imm();
        test_illegal();
        test_halt();
        test_wait();
        test_stall_illegal();
        test_wrap();
        test_reset_wait();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
